// File: rtl/gemm_inst_sequencer.sv
// Instruction fetch/decode/sequencer for the systolic GEMM array: runs a program from an
// internal instruction RAM and emits buffer strobes, addresses, skew steps and array control.
module gemm_inst_sequencer #(
    parameter int INST_WIDTH           = 16,
    parameter int OPCODE_WIDTH         = 4,
    parameter int BUF_ID_WIDTH         = 2,
    parameter int MEM_LOC_WIDTH        = 10,
    parameter int LOG2_INST_DEPTH      = 10,
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int CTRL_WIDTH           = 4,
    parameter int GEMM_CYCLES          = 11,
    parameter int DRAIN_CYCLES         = 6,
    parameter int CTRL_IDLE            = 0,
    parameter int CTRL_STEADY          = 1,
    parameter int CTRL_DRAIN           = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    imem_wr_en,
    input  logic [LOG2_INST_DEPTH-1:0]              imem_wr_addr,
    input  logic [INST_WIDTH-1:0]                   imem_wr_data,
    input  logic                                    start,
    input  logic [LOG2_INST_DEPTH-1:0]              start_pc,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    output logic [LOG2_INST_DEPTH-1:0]              pc,
    output logic [OPCODE_WIDTH-1:0]                 opcode,
    output logic [BUF_ID_WIDTH-1:0]                 buf_id,
    output logic [MEM_LOC_WIDTH-1:0]                mem_loc,
    output logic                                    i_left_wr_en,
    output logic                                    i_top_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_left_wr_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_top_wr_addr,
    output logic [$clog2(NUM_ROW+NUM_COL)-1:0]      ld_step,
    output logic                                    i_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_down_rd_addr,
    output logic                                    st_valid,
    output logic [$clog2(NUM_ROW)-1:0]              st_row,
    output logic [CTRL_WIDTH-1:0]                   i_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_left_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_left_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_top_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_top_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_down_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]         i_down_sram_rd_end_addr
);

    localparam int AW      = LOG2_SRAM_BANK_DEPTH;
    localparam int STEP_W  = $clog2(NUM_ROW+NUM_COL);
    localparam int ROW_W   = $clog2(NUM_ROW);
    localparam int LD_LEN  = NUM_ROW + NUM_COL - 1;
    localparam int MAX_A   = (LD_LEN > NUM_ROW) ? LD_LEN : NUM_ROW;
    localparam int MAX_B   = (GEMM_CYCLES > DRAIN_CYCLES) ? GEMM_CYCLES : DRAIN_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] LD_LAST    = CNT_W'(LD_LEN - 1);
    localparam logic [CNT_W-1:0] LD_DONE    = CNT_W'(LD_LEN);
    localparam logic [CNT_W-1:0] ST_LAST    = CNT_W'(NUM_ROW - 1);
    localparam logic [CNT_W-1:0] ST_DONE    = CNT_W'(NUM_ROW);
    localparam logic [CNT_W-1:0] GEMM_LAST  = CNT_W'(GEMM_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [AW-1:0]    ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0]    LD_SPAN    = AW'(LD_LEN - 1);
    localparam logic [AW-1:0]    ST_SPAN    = AW'(NUM_ROW - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [LOG2_INST_DEPTH-1:0] PC_ONE = LOG2_INST_DEPTH'(1);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD    = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ST    = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_GEMM  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_DRAIN = OPCODE_WIDTH'(5);
    localparam logic [BUF_ID_WIDTH-1:0] BUF_LEFT = BUF_ID_WIDTH'(0);
    localparam logic [BUF_ID_WIDTH-1:0] BUF_TOP  = BUF_ID_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_LD, S_ST, S_GEMM, S_DRAIN} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [INST_WIDTH-1:0]   imem [2**LOG2_INST_DEPTH];
    logic [INST_WIDTH-1:0]   inst_q;

    logic [OPCODE_WIDTH-1:0] dec_op;
    logic [BUF_ID_WIDTH-1:0] dec_buf;
    logic [AW-1:0]           dec_addr;
    logic [AW-1:0]           loc_addr;

    assign dec_op   = inst_q[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign dec_buf  = inst_q[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
    assign dec_addr = AW'(inst_q[MEM_LOC_WIDTH-1:0]);
    assign loc_addr = AW'(mem_loc);

    // NOTE: the instruction RAM and its read register carry no reset; clearing a RAM array
    // on reset defeats block-RAM mapping, and the host always writes the program first.
    always_ff @(posedge clk) begin
        if (imem_wr_en)
            imem[imem_wr_addr] <= imem_wr_data;
        if (state == S_FETCH)
            inst_q <= imem[pc];
    end

    // NOTE: all state uses non-blocking assignments so every register samples the values
    // from before the edge; this is also what makes the RAM above read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= S_IDLE;
            cnt                       <= '0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            err                       <= 1'b0;
            pc                        <= '0;
            opcode                    <= '0;
            buf_id                    <= '0;
            mem_loc                   <= '0;
            i_left_wr_en              <= 1'b0;
            i_top_wr_en               <= 1'b0;
            i_left_wr_addr            <= '0;
            i_top_wr_addr             <= '0;
            ld_step                   <= '0;
            i_down_rd_en              <= 1'b0;
            i_down_rd_addr            <= '0;
            st_valid                  <= 1'b0;
            st_row                    <= '0;
            i_ctrl_state              <= CTRL_WIDTH'(CTRL_IDLE);
            i_left_sram_rd_start_addr <= '0;
            i_left_sram_rd_end_addr   <= '0;
            i_top_sram_rd_start_addr  <= '0;
            i_top_sram_rd_end_addr    <= '0;
            i_down_sram_rd_start_addr <= '0;
            i_down_sram_rd_end_addr   <= '0;
        end else begin
            done     <= 1'b0;
            st_valid <= i_down_rd_en;
            if (i_down_rd_en)
                st_row <= ROW_W'(cnt);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                        pc    <= start_pc;
                        err   <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    opcode  <= dec_op;
                    buf_id  <= dec_buf;
                    mem_loc <= inst_q[MEM_LOC_WIDTH-1:0];
                    pc      <= pc + PC_ONE;
                    cnt     <= '0;
                    state   <= S_FETCH;
                    case (dec_op)
                        OP_NOP: ;
                        OP_HALT: begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        OP_LD: begin
                            if (dec_buf == BUF_LEFT) begin
                                state          <= S_LD;
                                i_left_wr_en   <= 1'b1;
                                i_left_wr_addr <= dec_addr;
                                ld_step        <= '0;
                            end else if (dec_buf == BUF_TOP) begin
                                state         <= S_LD;
                                i_top_wr_en   <= 1'b1;
                                i_top_wr_addr <= dec_addr;
                                ld_step       <= '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        OP_ST: begin
                            state          <= S_ST;
                            i_down_rd_en   <= 1'b1;
                            i_down_rd_addr <= dec_addr;
                        end
                        OP_GEMM: begin
                            state        <= S_GEMM;
                            i_ctrl_state <= CTRL_WIDTH'(CTRL_STEADY);
                        end
                        OP_DRAIN: begin
                            state        <= S_DRAIN;
                            i_ctrl_state <= CTRL_WIDTH'(CTRL_DRAIN);
                        end
                        default: err <= 1'b1;
                    endcase
                end
                S_LD: begin
                    // The cycle after the last write publishes the read window, then refetches.
                    if (cnt == LD_DONE) begin
                        state <= S_FETCH;
                    end else if (cnt == LD_LAST) begin
                        i_left_wr_en <= 1'b0;
                        i_top_wr_en  <= 1'b0;
                        cnt          <= cnt + CNT_ONE;
                        if (buf_id == BUF_LEFT) begin
                            i_left_sram_rd_start_addr <= loc_addr;
                            i_left_sram_rd_end_addr   <= loc_addr + LD_SPAN;
                        end else begin
                            i_top_sram_rd_start_addr <= loc_addr;
                            i_top_sram_rd_end_addr   <= loc_addr + LD_SPAN;
                        end
                    end else begin
                        cnt     <= cnt + CNT_ONE;
                        ld_step <= ld_step + STEP_ONE;
                        if (buf_id == BUF_LEFT)
                            i_left_wr_addr <= i_left_wr_addr + ADDR_ONE;
                        else
                            i_top_wr_addr <= i_top_wr_addr + ADDR_ONE;
                    end
                end
                S_ST: begin
                    if (cnt == ST_DONE) begin
                        state <= S_FETCH;
                    end else if (cnt == ST_LAST) begin
                        i_down_rd_en              <= 1'b0;
                        i_down_sram_rd_start_addr <= loc_addr;
                        i_down_sram_rd_end_addr   <= loc_addr + ST_SPAN;
                        cnt                       <= cnt + CNT_ONE;
                    end else begin
                        i_down_rd_addr <= i_down_rd_addr + ADDR_ONE;
                        cnt            <= cnt + CNT_ONE;
                    end
                end
                S_GEMM: begin
                    if (cnt == GEMM_LAST) begin
                        state        <= S_FETCH;
                        i_ctrl_state <= CTRL_WIDTH'(CTRL_IDLE);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state        <= S_FETCH;
                        i_ctrl_state <= CTRL_WIDTH'(CTRL_IDLE);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Directed bench for gemm_inst_sequencer: a program-level timing model builds the expected
// per-cycle outputs, and literal checks pin key cycle counts and windows.
module tb_gemm_inst_sequencer;

    localparam int L = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_wr_en = 1'b0;
    logic [9:0]  imem_wr_addr = '0;
    logic [15:0] imem_wr_data = '0;
    logic        start = 1'b0;
    logic [9:0]  start_pc = '0;

    logic        busy, done, err;
    logic [9:0]  pc;
    logic [3:0]  opcode;
    logic [1:0]  buf_id;
    logic [9:0]  mem_loc;
    logic        i_left_wr_en, i_top_wr_en;
    logic [9:0]  i_left_wr_addr, i_top_wr_addr;
    logic [3:0]  ld_step;
    logic        i_down_rd_en;
    logic [9:0]  i_down_rd_addr;
    logic        st_valid;
    logic [2:0]  st_row;
    logic [3:0]  i_ctrl_state;
    logic [9:0]  i_left_sram_rd_start_addr, i_left_sram_rd_end_addr;
    logic [9:0]  i_top_sram_rd_start_addr, i_top_sram_rd_end_addr;
    logic [9:0]  i_down_sram_rd_start_addr, i_down_sram_rd_end_addr;

    always #5 clk = ~clk;

    gemm_inst_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .start(start), .start_pc(start_pc),
        .busy(busy), .done(done), .err(err), .pc(pc),
        .opcode(opcode), .buf_id(buf_id), .mem_loc(mem_loc),
        .i_left_wr_en(i_left_wr_en), .i_top_wr_en(i_top_wr_en),
        .i_left_wr_addr(i_left_wr_addr), .i_top_wr_addr(i_top_wr_addr),
        .ld_step(ld_step),
        .i_down_rd_en(i_down_rd_en), .i_down_rd_addr(i_down_rd_addr),
        .st_valid(st_valid), .st_row(st_row),
        .i_ctrl_state(i_ctrl_state),
        .i_left_sram_rd_start_addr(i_left_sram_rd_start_addr),
        .i_left_sram_rd_end_addr(i_left_sram_rd_end_addr),
        .i_top_sram_rd_start_addr(i_top_sram_rd_start_addr),
        .i_top_sram_rd_end_addr(i_top_sram_rd_end_addr),
        .i_down_sram_rd_start_addr(i_down_sram_rd_start_addr),
        .i_down_sram_rd_end_addr(i_down_sram_rd_end_addr)
    );

    typedef struct packed {
        logic       busy, done, err;
        logic [9:0] pc;
        logic [3:0] op;
        logic [1:0] bid;
        logic [9:0] loc;
        logic       lwe, twe;
        logic [9:0] waddr;
        logic [3:0] step;
        logic       dre;
        logic [9:0] raddr;
        logic       stv;
        logic [2:0] srow;
        logic [3:0] ctrl;
        logic [9:0] ls, le, ts, te, ds, de;
    } exp_t;

    exp_t        trace[$];
    logic [15:0] mem_model [1024];
    logic        m_err;
    logic [3:0]  m_op;
    logic [1:0]  m_bid;
    logic [9:0]  m_loc, m_ls, m_le, m_ts, m_te, m_ds, m_de;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_lwe, obs_twe, obs_c1, obs_c2, obs_stv, obs_done_cycle, obs_first_lwe;

    task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %0h, required %0h", name, c, act, exp);
        end
    endtask

    task automatic model_reset();
        m_err = 1'b0; m_op = '0; m_bid = '0; m_loc = '0;
        m_ls = '0; m_le = '0; m_ts = '0; m_te = '0; m_ds = '0; m_de = '0;
    endtask

    function automatic exp_t base(input logic [9:0] a);
        exp_t e;
        e      = '0;
        e.busy = 1'b1;
        e.err  = m_err;
        e.pc   = a;
        e.op   = m_op;  e.bid = m_bid; e.loc = m_loc;
        e.ls   = m_ls;  e.le  = m_le;
        e.ts   = m_ts;  e.te  = m_te;
        e.ds   = m_ds;  e.de  = m_de;
        return e;
    endfunction

    // Walk the program from spc and lay out what every output must show, cycle by cycle.
    task automatic build(input logic [9:0] spc);
        exp_t        e;
        logic [9:0]  a;
        logic [15:0] w;
        bit          halted = 0;
        trace.delete();
        m_err = 1'b0;
        a = spc;
        for (int n = 0; n < 50 && !halted; n++) begin
            w = mem_model[a];
            trace.push_back(base(a));
            trace.push_back(base(a));
            m_op = w[15:12]; m_bid = w[11:10]; m_loc = w[9:0];
            a = a + 10'd1;
            case (m_op)
                4'd0: ;
                4'd1: begin
                    e = base(a); e.busy = 1'b0; e.done = 1'b1;
                    trace.push_back(e);
                    halted = 1;
                end
                4'd2: begin
                    if (m_bid[1]) m_err = 1'b1;
                    else begin
                        for (int k = 0; k < L; k++) begin
                            e = base(a);
                            if (m_bid == 2'd0) e.lwe = 1'b1; else e.twe = 1'b1;
                            e.waddr = m_loc + 10'(k);
                            e.step  = 4'(k);
                            trace.push_back(e);
                        end
                        if (m_bid == 2'd0) begin m_ls = m_loc; m_le = m_loc + 10'(L - 1); end
                        else begin m_ts = m_loc; m_te = m_loc + 10'(L - 1); end
                        trace.push_back(base(a));
                    end
                end
                4'd3: begin
                    for (int i = 0; i < 8; i++) begin
                        e = base(a);
                        e.dre = 1'b1; e.raddr = m_loc + 10'(i);
                        if (i > 0) begin e.stv = 1'b1; e.srow = 3'(i - 1); end
                        trace.push_back(e);
                    end
                    m_ds = m_loc; m_de = m_loc + 10'd7;
                    e = base(a); e.stv = 1'b1; e.srow = 3'd7;
                    trace.push_back(e);
                end
                4'd4: for (int i = 0; i < 11; i++) begin e = base(a); e.ctrl = 4'd1; trace.push_back(e); end
                4'd5: for (int i = 0; i < 6; i++) begin e = base(a); e.ctrl = 4'd2; trace.push_back(e); end
                default: m_err = 1'b1;
            endcase
        end
        for (int i = 0; i < 3; i++) begin
            e = base(a); e.busy = 1'b0;
            trace.push_back(e);
        end
    endtask

    task automatic compare(input int c, input exp_t e);
        check("busy", c, busy, e.busy);
        check("done", c, done, e.done);
        check("err", c, err, e.err);
        check("pc", c, pc, e.pc);
        check("fields", c, {opcode, buf_id, mem_loc}, {e.op, e.bid, e.loc});
        check("left_wr_en", c, i_left_wr_en, e.lwe);
        check("top_wr_en", c, i_top_wr_en, e.twe);
        if (e.lwe) check("left_wr_addr", c, i_left_wr_addr, e.waddr);
        if (e.twe) check("top_wr_addr", c, i_top_wr_addr, e.waddr);
        if (e.lwe || e.twe) check("ld_step", c, ld_step, e.step);
        check("down_rd_en", c, i_down_rd_en, e.dre);
        if (e.dre) check("down_rd_addr", c, i_down_rd_addr, e.raddr);
        check("st_valid", c, st_valid, e.stv);
        if (e.stv) check("st_row", c, st_row, e.srow);
        check("ctrl_state", c, i_ctrl_state, e.ctrl);
        check("left_window", c, {i_left_sram_rd_start_addr, i_left_sram_rd_end_addr}, {e.ls, e.le});
        check("top_window", c, {i_top_sram_rd_start_addr, i_top_sram_rd_end_addr}, {e.ts, e.te});
        check("down_window", c, {i_down_sram_rd_start_addr, i_down_sram_rd_end_addr}, {e.ds, e.de});
    endtask

    task automatic observe(input int c);
        if (i_left_wr_en) begin obs_lwe++; if (obs_first_lwe < 0) obs_first_lwe = c; end
        if (i_top_wr_en) obs_twe++;
        if (i_ctrl_state == 4'd1) obs_c1++;
        if (i_ctrl_state == 4'd2) obs_c2++;
        if (st_valid) obs_stv++;
        if (done && obs_done_cycle < 0) obs_done_cycle = c;
    endtask

    task automatic load(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        imem_wr_en = 1'b1; imem_wr_addr = a; imem_wr_data = d;
        mem_model[a] = d;
        @(negedge clk);
        imem_wr_en = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run(input logic [9:0] spc, input int inj_cycle, input logic [9:0] inj_addr,
                       input logic [15:0] inj_data, input int restart_cycle);
        build(spc);
        if (inj_cycle > 0) mem_model[inj_addr] = inj_data;
        obs_lwe = 0; obs_twe = 0; obs_c1 = 0; obs_c2 = 0; obs_stv = 0;
        obs_done_cycle = -1; obs_first_lwe = -1;
        @(negedge clk);
        start = 1'b1; start_pc = spc;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= trace.size(); c++) begin
            imem_wr_en = 1'b0;
            start      = 1'b0;
            compare(c, trace[c-1]);
            observe(c);
            if (c == inj_cycle) begin
                imem_wr_en = 1'b1; imem_wr_addr = inj_addr; imem_wr_data = inj_data;
            end
            if (c == restart_cycle) begin
                start = 1'b1; start_pc = 10'd500;
            end
            @(negedge clk);
        end
        imem_wr_en = 1'b0;
        start      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, 0, {busy, done, err, pc, opcode, buf_id, mem_loc}, 64'd0);
        check({tag, "_strobes"}, 0, {i_left_wr_en, i_top_wr_en, i_left_wr_addr, i_top_wr_addr, ld_step,
              i_down_rd_en, i_down_rd_addr, st_valid, st_row, i_ctrl_state}, 64'd0);
        check({tag, "_lt_windows"}, 0, {i_left_sram_rd_start_addr, i_left_sram_rd_end_addr,
              i_top_sram_rd_start_addr, i_top_sram_rd_end_addr}, 64'd0);
        check({tag, "_down_window"}, 0, {i_down_sram_rd_start_addr, i_down_sram_rd_end_addr}, 64'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_release");

        // LD left loc 0, HALT
        load(10'd0, 16'h2000);
        load(10'd1, 16'h1000);
        run(10'd0, 0, '0, '0, 0);
        check("A_left_writes", 0, obs_lwe, 64'd15);
        check("A_first_write_cycle", 0, obs_first_lwe, 64'd3);
        check("A_done_cycle", 0, obs_done_cycle, 64'd21);
        check("A_left_window", 0, {i_left_sram_rd_start_addr, i_left_sram_rd_end_addr}, {10'd0, 10'd14});

        // LD top loc 1020 wraps the write address and the window end
        load(10'd10, 16'h27FC);
        load(10'd11, 16'h1000);
        run(10'd10, 0, '0, '0, 0);
        check("B_top_writes", 0, obs_twe, 64'd15);
        check("B_top_window", 0, {i_top_sram_rd_start_addr, i_top_sram_rd_end_addr}, {10'd1020, 10'd10});

        // GEMM, DRAINSYS, HALT with an ignored start while busy
        load(10'd20, 16'h4000);
        load(10'd21, 16'h5000);
        load(10'd22, 16'h1000);
        run(10'd20, 0, '0, '0, 5);
        check("C_steady_cycles", 0, obs_c1, 64'd11);
        check("C_drain_cycles", 0, obs_c2, 64'd6);
        check("C_done_cycle", 0, obs_done_cycle, 64'd24);

        // ST loc 5
        load(10'd30, 16'h3005);
        load(10'd31, 16'h1000);
        run(10'd30, 0, '0, '0, 0);
        check("D_st_valid_cycles", 0, obs_stv, 64'd8);
        check("D_down_window", 0, {i_down_sram_rd_start_addr, i_down_sram_rd_end_addr}, {10'd5, 10'd12});

        // Illegal opcode, LD with buf 10, HALT; then a fresh start clears err
        load(10'd40, 16'hF000);
        load(10'd41, 16'h2800);
        load(10'd42, 16'h1000);
        run(10'd40, 0, '0, '0, 0);
        check("E_err_set", 0, err, 64'd1);
        check("E_no_writes", 0, obs_lwe + obs_twe, 64'd0);
        check("E_done_cycle", 0, obs_done_cycle, 64'd7);
        load(10'd50, 16'h1000);
        run(10'd50, 0, '0, '0, 0);
        check("E_err_cleared", 0, err, 64'd0);

        // PC wrap at 1023 and a read-first write to the address being fetched
        load(10'd1023, 16'h0000);
        load(10'd0, 16'h1000);
        run(10'd1023, 1, 10'd1023, 16'h1000, 0);
        check("F_done_cycle", 0, obs_done_cycle, 64'd5);
        check("F_pc_after_wrap", 0, pc, 64'd1);
        run(10'd1023, 0, '0, '0, 0);
        check("F2_done_cycle", 0, obs_done_cycle, 64'd3);
        check("F2_pc_wrapped", 0, pc, 64'd0);

        // Asynchronous reset in the middle of an LD burst (k = 4)
        load(10'd60, 16'h2064);
        load(10'd61, 16'h1000);
        @(negedge clk);
        start = 1'b1; start_pc = 10'd60;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("G_mid_ld_en", 7, i_left_wr_en, 64'd1);
        check("G_mid_ld_addr", 7, i_left_wr_addr, 64'd104);
        check("G_mid_ld_step", 7, ld_step, 64'd4);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("G_idle_busy", i, busy, 64'd0);
            check("G_idle_strobes", i, {i_left_wr_en, i_top_wr_en, i_down_rd_en, st_valid, i_ctrl_state}, 64'd0);
        end
        run(10'd61, 0, '0, '0, 0);
        check("G_done_cycle", 0, obs_done_cycle, 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
